// File: rtl/alu_muldiv_control.sv
// alu_muldiv_control
// Execute-stage ALU control decoder with an iterative multiply/divide engine.
// The {alu_op, funct} pair is decoded combinationally into a 4-bit ALU
// operation select. MULT/MULTU/DIV/DIVU are handed to a shift-add multiplier /
// restoring divider that produces one bit per cycle and owns the HI/LO
// registers. MFHI/MFLO read HI/LO, and the engine stalls the pipeline when an
// instruction needs it while it is still iterating.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-low; clears all state
//   alu_op_i         ALU op class from the main control unit
//   alu_function_i   instruction funct field
//   valid_i          EX stage holds a real instruction this cycle
//   rs_data_i        multiplicand / dividend
//   rt_data_i        multiplier / divisor
//   alu_operation_o  ALU operation select (combinational)
//   hilo_data_o      HI for MFHI, LO for MFLO, else 0
//   hilo_sel_o       writeback takes hilo_data_o instead of the ALU result
//   stall_o          hold IF/ID/EX this cycle (combinational)
//   busy_o           engine iterating
//   div_by_zero_o    last accepted divide had a zero divisor (sticky)

module alu_muldiv_control #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            alu_op_i,
    input  logic [5:0]            alu_function_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] rs_data_i,
    input  logic [DATA_WIDTH-1:0] rt_data_i,
    output logic [3:0]            alu_operation_o,
    output logic [DATA_WIDTH-1:0] hilo_data_o,
    output logic                  hilo_sel_o,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  div_by_zero_o
);

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]         hi_q, hi_d;
    logic [W-1:0]         lo_q, lo_d;
    // Shared work register: {accumulator, multiplier} for MUL,
    // {partial remainder, dividend/quotient} for DIV.
    logic [2*W-1:0]       work_q, work_d;
    // Multiplicand magnitude for MUL, divisor magnitude for DIV.
    logic [W-1:0]         opnd_q, opnd_d;
    logic                 res_neg_q, res_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 unsigned_q, unsigned_d;
    logic                 dz_pend_q, dz_pend_d;
    logic                 dz_q, dz_d;

    // Instruction classification
    logic is_rtype, is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo;
    logic is_mul_any, is_div_any, is_muldiv, is_move, signed_op, accept;

    assign is_rtype   = (alu_op_i == 3'b111);
    assign is_mult    = is_rtype & (alu_function_i == FN_MULT);
    assign is_multu   = is_rtype & (alu_function_i == FN_MULTU);
    assign is_div     = is_rtype & (alu_function_i == FN_DIV);
    assign is_divu    = is_rtype & (alu_function_i == FN_DIVU);
    assign is_mfhi    = is_rtype & (alu_function_i == FN_MFHI);
    assign is_mflo    = is_rtype & (alu_function_i == FN_MFLO);
    assign is_mul_any = is_mult | is_multu;
    assign is_div_any = is_div | is_divu;
    assign is_muldiv  = is_mul_any | is_div_any;
    assign is_move    = is_mfhi | is_mflo;
    assign signed_op  = is_mult | is_div;
    assign accept     = valid_i & is_muldiv & (state_q == S_IDLE);

    // Operand magnitudes; unary minus gives the two's-complement absolute
    // value, and the most-negative value maps onto itself as an unsigned
    // magnitude, which is exactly what the iteration needs.
    logic rs_neg, rt_neg;
    logic [W-1:0] rs_mag, rt_mag;

    assign rs_neg = signed_op & rs_data_i[W-1];
    assign rt_neg = signed_op & rt_data_i[W-1];
    assign rs_mag = rs_neg ? -rs_data_i : rs_data_i;
    assign rt_mag = rt_neg ? -rt_data_i : rt_data_i;

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit (LSB) is set, then shift the whole pair right.
    logic [W-1:0]   mul_addend;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;

    assign mul_addend = work_q[0] ? opnd_q : {W{1'b0}};
    assign mul_sum    = {1'b0, work_q[2*W-1:W]} + {1'b0, mul_addend};
    assign mul_next   = {mul_sum, work_q[W-1:1]};

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor only if it fits; the outcome is the quotient bit
    // shifted into the low end. The partial remainder is always below the
    // divisor, so the shifted value fits in W+1 bits and a fitting
    // difference fits in W bits.
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [W-1:0]   div_rem_next;
    logic [2*W-1:0] div_next;

    assign div_shift    = {work_q[2*W-1:W], work_q[W-1]};
    assign div_ge       = (div_shift >= {1'b0, opnd_q});
    assign div_diff     = div_shift[W-1:0] - opnd_q;
    assign div_rem_next = div_ge ? div_diff : div_shift[W-1:0];
    assign div_next     = {div_rem_next, work_q[W-2:0], div_ge};

    // Sign fix-up applied on the final cycle. A zero divisor leaves the
    // dividend magnitude as remainder (so HI comes back as rs once the
    // dividend sign is restored) and forces the quotient to all ones.
    logic [2*W-1:0] prod_fin;
    logic [W-1:0]   quo_raw, rem_raw, quo_fin, rem_fin;
    logic           neg_res, neg_rem;

    assign neg_res  = res_neg_q & ~unsigned_q;
    assign neg_rem  = rem_neg_q & ~unsigned_q;
    assign prod_fin = neg_res ? -mul_next : mul_next;
    assign quo_raw  = div_next[W-1:0];
    assign rem_raw  = div_next[2*W-1:W];
    assign quo_fin  = dz_pend_q ? {W{1'b1}} : (neg_res ? -quo_raw : quo_raw);
    assign rem_fin  = neg_rem ? -rem_raw : rem_raw;

    // Legacy ALU decode; every muldiv/move funct falls into the idle code.
    always_comb begin
        alu_operation_o = 4'b1001;
        case (alu_op_i)
            3'b111: begin
                case (alu_function_i)
                    6'b100000: alu_operation_o = 4'b0011;
                    6'b100010: alu_operation_o = 4'b0101;
                    6'b100101: alu_operation_o = 4'b0001;
                    6'b000000: alu_operation_o = 4'b0010;
                    6'b000010: alu_operation_o = 4'b0100;
                    default:   alu_operation_o = 4'b1001;
                endcase
            end
            3'b100:  alu_operation_o = 4'b0011;
            3'b000:  alu_operation_o = 4'b0000;
            3'b001:  alu_operation_o = 4'b0001;
            default: alu_operation_o = 4'b1001;
        endcase
    end

    // Engine next-state: accept in IDLE, iterate, write HI/LO on the last
    // iteration while returning to IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        work_d     = work_q;
        opnd_d     = opnd_q;
        res_neg_d  = res_neg_q;
        rem_neg_d  = rem_neg_q;
        unsigned_d = unsigned_q;
        dz_pend_d  = dz_pend_q;
        dz_d       = dz_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d      = '0;
                    unsigned_d = is_multu | is_divu;
                    res_neg_d  = rs_data_i[W-1] ^ rt_data_i[W-1];
                    rem_neg_d  = rs_data_i[W-1];
                    dz_d       = 1'b0;
                    dz_pend_d  = is_div_any & (rt_data_i == {W{1'b0}});
                    if (is_mul_any) begin
                        state_d = S_MUL;
                        opnd_d  = rs_mag;
                        work_d  = {{W{1'b0}}, rt_mag};
                    end else begin
                        state_d = S_DIV;
                        opnd_d  = rt_mag;
                        work_d  = {{W{1'b0}}, rs_mag};
                    end
                end
            end
            S_MUL: begin
                work_d = mul_next;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_IDLE;
                    hi_d    = prod_fin[2*W-1:W];
                    lo_d    = prod_fin[W-1:0];
                end
            end
            S_DIV: begin
                work_d = div_next;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_IDLE;
                    hi_d    = rem_fin;
                    lo_d    = quo_fin;
                    dz_d    = dz_pend_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            work_q     <= '0;
            opnd_q     <= '0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            unsigned_q <= 1'b0;
            dz_pend_q  <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            work_q     <= work_d;
            opnd_q     <= opnd_d;
            res_neg_q  <= res_neg_d;
            rem_neg_q  <= rem_neg_d;
            unsigned_q <= unsigned_d;
            dz_pend_q  <= dz_pend_d;
            dz_q       <= dz_d;
        end
    end

    // Pipeline-facing outputs
    always_comb begin
        hilo_data_o = '0;
        if (valid_i & is_mfhi) begin
            hilo_data_o = hi_q;
        end else if (valid_i & is_mflo) begin
            hilo_data_o = lo_q;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign stall_o       = valid_i & (is_move | is_muldiv) & busy_o;
    assign hilo_sel_o    = valid_i & is_move & ~busy_o;
    assign div_by_zero_o = dz_q;

endmodule

// File: tb/tb_alu_muldiv_control.sv
// tb_alu_muldiv_control
// Self-checking bench for alu_muldiv_control (DATA_WIDTH = 32). Results are
// predicted with plain 64-bit arithmetic and the language's own divide and
// modulo operators, and HI/LO are observed only through MFHI/MFLO.

module tb_alu_muldiv_control;

    localparam int DW = 32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic          clk;
    logic          reset;
    logic [2:0]    aluOp;
    logic [5:0]    aluFunct;
    logic          valid;
    logic [DW-1:0] rsData;
    logic [DW-1:0] rtData;
    logic [3:0]    aluOperation;
    logic [DW-1:0] hiloData;
    logic          hiloSel;
    logic          stall;
    logic          busy;
    logic          divByZero;

    int checks = 0;
    int errors = 0;

    // Results of the most recent runMuldiv call
    logic [DW-1:0] resHi, resLo;
    int            resBusy;
    logic          resTimeout, resAccStall;

    alu_muldiv_control #(.DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_op_i        (aluOp),
        .alu_function_i  (aluFunct),
        .valid_i         (valid),
        .rs_data_i       (rsData),
        .rt_data_i       (rtData),
        .alu_operation_o (aluOperation),
        .hilo_data_o     (hiloData),
        .hilo_sel_o      (hiloSel),
        .stall_o         (stall),
        .busy_o          (busy),
        .div_by_zero_o   (divByZero)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Last-resort guard so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "[TB] watchdog");
    end

    // Expected ALU select, straight from the decode table
    function automatic logic [3:0] refDecode(input logic [2:0] op, input logic [5:0] fn);
        if (op == 3'b111) begin
            case (fn)
                6'b100000: return 4'b0011;
                6'b100010: return 4'b0101;
                6'b100101: return 4'b0001;
                6'b000000: return 4'b0010;
                6'b000010: return 4'b0100;
                default:   return 4'b1001;
            endcase
        end
        if (op == 3'b100) return 4'b0011;
        if (op == 3'b000) return 4'b0000;
        if (op == 3'b001) return 4'b0001;
        return 4'b1001;
    endfunction

    // Expected HI/LO/divide-by-zero from arithmetic on the operands
    function automatic void refMuldiv(input logic [5:0] fn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                      output logic [DW-1:0] hi, output logic [DW-1:0] lo, output logic dz);
        longint      sp;
        logic [63:0] up;
        int          q, r;
        hi = '0;
        lo = '0;
        dz = 1'b0;
        case (fn)
            F_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
                hi = up[63:32];
                lo = up[31:0];
            end
            F_MULTU: begin
                up = {32'h0, a} * {32'h0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            F_DIV: begin
                if (b == 0) begin
                    lo = '1; hi = a; dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = '0;
                end else begin
                    q  = $signed(a) / $signed(b);
                    r  = $signed(a) % $signed(b);
                    lo = q;
                    hi = r;
                end
            end
            default: begin
                if (b == 0) begin
                    lo = '1; hi = a; dz = 1'b1;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Drive one EX-stage instruction slot
    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [5:0] fn,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
        valid    = v;
        aluOp    = op;
        aluFunct = fn;
        rsData   = a;
        rtData   = b;
    endtask

    // Issue one muldiv op on an idle engine, count busy cycles, then read
    // HI and LO back through MFHI/MFLO in the first cycles after completion.
    task automatic runMuldiv(input logic [5:0] fn, input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        applyStimulus(1'b1, 3'b111, fn, a, b);
        #1 resAccStall = stall;
        resBusy    = 0;
        resTimeout = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 3'b000, 6'h00, '0, '0);
            #1;
            if (busy) begin
                resBusy++;
            end else begin
                resTimeout = 1'b0;
                break;
            end
        end
        applyStimulus(1'b1, 3'b111, F_MFHI, '0, '0);
        #1 resHi = hiloData;
        @(negedge clk);
        applyStimulus(1'b1, 3'b111, F_MFLO, '0, '0);
        #1 resLo = hiloData;
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 6'h00, '0, '0);
    endtask

    // Reset values of every output
    task automatic test_reset();
        applyStimulus(1'b0, 3'b000, 6'h00, '0, '0);
        reset = 1'b0;
        #13;
        checks++;
        if ({busy, divByZero, stall, hiloSel} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, divByZero, stall, hiloSel});
        end
        checks++;
        if (hiloData !== '0) begin
            errors++;
            $display("[TB] FAIL reset_hilo_data: got %h expected 0", hiloData);
        end
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 3'b111, F_MFHI, '0, '0);
        #1;
        checks++;
        if (hiloData !== '0 || hiloSel !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mfhi: got data=%h sel=%b stall=%b expected data=0 sel=1 stall=0",
                     hiloData, hiloSel, stall);
        end
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 6'h00, '0, '0);
    endtask

    // Every op class against a set of functs, including the new ones
    task automatic test_decode();
        logic [5:0] fnList[14];
        fnList = '{6'b100000, 6'b100010, 6'b100101, 6'b000000, 6'b000010, 6'b110000,
                   F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, 6'b111111, 6'b000001};
        for (int op = 0; op < 8; op++) begin
            for (int k = 0; k < 14; k++) begin
                @(negedge clk);
                applyStimulus(1'b0, 3'(op), fnList[k], $urandom, $urandom);
                #1;
                checks++;
                if (aluOperation !== refDecode(3'(op), fnList[k])) begin
                    errors++;
                    $display("[TB] FAIL decode op=%b fn=%b: got %b expected %b",
                             3'(op), fnList[k], aluOperation, refDecode(3'(op), fnList[k]));
                end
            end
        end
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 6'h00, '0, '0);
    endtask

    // MULT -3 x 5 with MFHI issued right behind it, then the same op timed
    task automatic test_mult_stall();
        int   stalls;
        logic done;
        @(negedge clk);
        applyStimulus(1'b1, 3'b111, F_MULT, 32'hFFFF_FFFD, 32'd5);
        @(negedge clk);
        applyStimulus(1'b1, 3'b111, F_MFHI, '0, '0);
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        checks++;
        if (!done || stalls != DW) begin
            errors++;
            $display("[TB] FAIL mfhi_stall_cycles: got %0d (done=%b) expected %0d", stalls, done, DW);
        end
        checks++;
        if (hiloData !== 32'hFFFF_FFFF || hiloSel !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mfhi_after_stall: got data=%h sel=%b expected data=ffffffff sel=1",
                     hiloData, hiloSel);
        end
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 6'h00, '0, '0);

        runMuldiv(F_MULT, 32'hFFFF_FFFD, 32'd5);
        checks++;
        if (resTimeout || resBusy != DW) begin
            errors++;
            $display("[TB] FAIL mult_busy_cycles: got %0d (timeout=%b) expected %0d", resBusy, resTimeout, DW);
        end
        checks++;
        if (resAccStall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mult_accept_stall: got %b expected 0", resAccStall);
        end
        checks++;
        if (resHi !== 32'hFFFF_FFFF || resLo !== 32'hFFFF_FFF1) begin
            errors++;
            $display("[TB] FAIL mult_neg3x5: got hi=%h lo=%h expected hi=ffffffff lo=fffffff1", resHi, resLo);
        end
    endtask

    // Unsigned and signed corner cases from the operation rules
    task automatic test_directed();
        logic [5:0]    fns[4];
        logic [DW-1:0] as[4], bs[4];
        logic [DW-1:0] eHi, eLo;
        logic          eDz;
        fns = '{F_DIVU, F_MULTU, F_DIV, F_DIV};
        as  = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000};
        bs  = '{32'd7,   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
        for (int k = 0; k < 4; k++) begin
            runMuldiv(fns[k], as[k], bs[k]);
            refMuldiv(fns[k], as[k], bs[k], eHi, eLo, eDz);
            checks++;
            if (resTimeout || resHi !== eHi || resLo !== eLo) begin
                errors++;
                $display("[TB] FAIL directed_%0d fn=%b a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h",
                         k, fns[k], as[k], bs[k], resHi, resLo, eHi, eLo);
            end
        end
        // MFHI with valid low must not leak HI onto the data bus
        @(negedge clk);
        applyStimulus(1'b0, 3'b111, F_MFHI, '0, '0);
        #1;
        checks++;
        if (hiloData !== '0 || hiloSel !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL invalid_mfhi: got data=%h sel=%b stall=%b expected 0/0/0", hiloData, hiloSel, stall);
        end
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 6'h00, '0, '0);
    endtask

    // Divide by zero sets the sticky flag; the next accepted op clears it
    task automatic test_div_zero();
        logic done;
        runMuldiv(F_DIV, 32'd9, 32'd0);
        checks++;
        if (resTimeout || resBusy != DW || resHi !== 32'd9 || resLo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL div9by0: got hi=%h lo=%h busy=%0d expected hi=9 lo=ffffffff busy=%0d",
                     resHi, resLo, resBusy, DW);
        end
        checks++;
        if (divByZero !== 1'b1) begin
            errors++;
            $display("[TB] FAIL div_by_zero_set: got %b expected 1", divByZero);
        end
        @(negedge clk);
        applyStimulus(1'b1, 3'b111, F_MULT, 32'd2, 32'd3);
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 6'h00, '0, '0);
        #1;
        checks++;
        if (divByZero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL div_by_zero_clear: got %b expected 0", divByZero);
        end
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL div_zero_drain: got busy expected idle within 100 cycles");
        end
    endtask

    // Second muldiv right behind the first waits exactly DATA_WIDTH cycles
    task automatic test_back_to_back();
        int            stalls;
        logic          done;
        logic [DW-1:0] a, b, eHi, eLo;
        logic          eDz;
        a = $urandom;
        b = $urandom_range(1, 1000);
        @(negedge clk);
        applyStimulus(1'b1, 3'b111, F_MULT, $urandom, $urandom);
        @(negedge clk);
        applyStimulus(1'b1, 3'b111, F_DIVU, a, b);
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        checks++;
        if (!done || stalls != DW) begin
            errors++;
            $display("[TB] FAIL b2b_stall_cycles: got %0d (done=%b) expected %0d", stalls, done, DW);
        end
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 6'h00, '0, '0);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_second_accept: got busy=%b expected 1", busy);
        end
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        applyStimulus(1'b1, 3'b111, F_MFHI, '0, '0);
        #1 resHi = hiloData;
        @(negedge clk);
        applyStimulus(1'b1, 3'b111, F_MFLO, '0, '0);
        #1 resLo = hiloData;
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 6'h00, '0, '0);
        refMuldiv(F_DIVU, a, b, eHi, eLo, eDz);
        checks++;
        if (!done || resHi !== eHi || resLo !== eLo) begin
            errors++;
            $display("[TB] FAIL b2b_divu a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h",
                     a, b, resHi, resLo, eHi, eLo);
        end
    endtask

    // Random operations of all four kinds against the arithmetic model
    task automatic test_random();
        logic [5:0]    fns[4];
        logic [5:0]    fn;
        logic [DW-1:0] a, b, eHi, eLo;
        logic          eDz;
        fns = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        for (int n = 0; n < 24; n++) begin
            fn = fns[$urandom_range(0, 3)];
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 3);
                1:       b = -$urandom_range(1, 9);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
            runMuldiv(fn, a, b);
            refMuldiv(fn, a, b, eHi, eLo, eDz);
            checks++;
            if (resTimeout || resBusy != DW || resHi !== eHi || resLo !== eLo || divByZero !== eDz) begin
                errors++;
                $display("[TB] FAIL random_%0d fn=%b a=%h b=%h: got hi=%h lo=%h dz=%b busy=%0d expected hi=%h lo=%h dz=%b busy=%0d",
                         n, fn, a, b, resHi, resLo, divByZero, resBusy, eHi, eLo, eDz, DW);
            end
        end
    endtask

    // Asynchronous reset in the middle of a MULT discards the result
    task automatic test_reset_mid();
        @(negedge clk);
        applyStimulus(1'b1, 3'b111, F_MULT, 32'd123456, 32'd789);
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 6'h00, '0, '0);
        repeat (9) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_pre_busy: got %b expected 1", busy);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_busy: got %b expected 0", busy);
        end
        applyStimulus(1'b1, 3'b111, F_MFLO, '0, '0);
        #1;
        checks++;
        if (hiloData !== '0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_lo: got data=%h stall=%b expected 0/0", hiloData, stall);
        end
        applyStimulus(1'b1, 3'b111, F_MFHI, '0, '0);
        #1;
        checks++;
        if (hiloData !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_hi: got %h expected 0", hiloData);
        end
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 3'b000, 6'h00, '0, '0);
        repeat (40) @(negedge clk);
        applyStimulus(1'b1, 3'b111, F_MFLO, '0, '0);
        #1;
        checks++;
        if (hiloData !== '0 || stall !== 1'b0 || hiloSel !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_after: got data=%h stall=%b sel=%b busy=%b expected 0/0/1/0",
                     hiloData, stall, hiloSel, busy);
        end
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 6'h00, '0, '0);
    endtask

    // Run every scenario in sequence and report
    initial begin
        test_reset();
        test_decode();
        test_mult_stall();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
